// File: rtl/vga_draw_scheduler_if.sv
// Bus between the draw scheduler, its draw engines and the VGA adapter write port.
interface vga_draw_scheduler_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned C_W   = 9
);
    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     engine_resetn;
    logic [N_REQ-1:0]     engine_done;
    logic [N_REQ*X_W-1:0] engine_x;
    logic [N_REQ*Y_W-1:0] engine_y;
    logic [N_REQ*C_W-1:0] engine_colour;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [C_W-1:0]       vga_colour;
    logic                 vga_plot;
    logic                 busy;
    logic [GW-1:0]        grant_id;
    logic [N_REQ-1:0]     done_pulse;
    logic                 timeout_err;

    // Scheduler side.
    modport master (
        input  req, engine_done, engine_x, engine_y, engine_colour,
        output engine_resetn, vga_x, vga_y, vga_colour, vga_plot,
               busy, grant_id, done_pulse, timeout_err
    );

    // Requester / engine / adapter side.
    modport slave (
        output req, engine_done, engine_x, engine_y, engine_colour,
        input  engine_resetn, vga_x, vga_y, vga_colour, vga_plot,
               busy, grant_id, done_pulse, timeout_err
    );
endinterface

// File: rtl/vga_draw_scheduler.sv
// Round-robin scheduler that lends the single VGA write port to one full-region
// draw engine at a time, holding all other engines in reset.
module vga_draw_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned X_W        = 8,
    parameter int unsigned Y_W        = 7,
    parameter int unsigned C_W        = 9,
    parameter int unsigned PLOT_SKIP  = 2,
    parameter int unsigned DRAIN      = 1,
    parameter int unsigned MAX_CYCLES = 16384
) (
    input logic                  clk,
    input logic                  resetn,
    vga_draw_scheduler_if.master bus
);
    localparam int unsigned GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TOP_A   = (MAX_CYCLES > PLOT_SKIP) ? MAX_CYCLES : PLOT_SKIP;
    localparam int unsigned CNT_TOP = (TOP_A > DRAIN) ? TOP_A : DRAIN;
    localparam int unsigned CW      = $clog2(CNT_TOP + 1);

    // Terminal counts; a zero-length START still occupies one cycle.
    localparam logic [CW-1:0] SKIP_LAST  = CW'((PLOT_SKIP == 0) ? 0 : PLOT_SKIP - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN == 0) ? 0 : DRAIN - 1);
    localparam logic [CW-1:0] RUN_LAST   = CW'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t          state, state_d;
    logic [GW-1:0]   grant_id_q, grant_d;
    logic [GW-1:0]   rr_ptr, rr_ptr_d;
    logic            rr_valid, rr_valid_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            timeout_q, timeout_d;

    logic [GW-1:0]    arb_win;
    int unsigned      arb_start;
    int unsigned      arb_idx;
    logic             arb_found;
    logic [N_REQ-1:0] grant_oh;
    logic             done_sel;

    // Round-robin search from the slot after the last completed grant (slot 0 after reset).
    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        arb_idx   = 0;
        arb_start = rr_valid ? 32'(rr_ptr) + 1 : 0;
        if (arb_start >= N_REQ) begin
            arb_start = 0;
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            arb_idx = arb_start + k;
            if (arb_idx >= N_REQ) begin
                arb_idx = arb_idx - N_REQ;
            end
            if (!arb_found && bus.req[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = GW'(arb_idx);
            end
        end
    end

    // Port mux and per-grant decode; pixel data follows grant_id in every state.
    always_comb begin
        bus.vga_x      = '0;
        bus.vga_y      = '0;
        bus.vga_colour = '0;
        grant_oh       = '0;
        done_sel       = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                bus.vga_x      = bus.engine_x[i*X_W +: X_W];
                bus.vga_y      = bus.engine_y[i*Y_W +: Y_W];
                bus.vga_colour = bus.engine_colour[i*C_W +: C_W];
                grant_oh[i]    = 1'b1;
                done_sel       = bus.engine_done[i];
            end
        end
    end

    // Next-state and Moore outputs of the grant sequencer.
    always_comb begin
        state_d           = state;
        grant_d           = grant_id_q;
        rr_ptr_d          = rr_ptr;
        rr_valid_d        = rr_valid;
        cnt_d             = cnt;
        timeout_d         = timeout_q;
        bus.engine_resetn = '0;
        bus.vga_plot      = 1'b0;
        bus.done_pulse    = '0;
        bus.busy          = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (|bus.req) begin
                    grant_d = arb_win;
                    state_d = S_START;
                end
            end
            S_START: begin
                bus.engine_resetn = grant_oh;
                if (cnt == SKIP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RUN: begin
                bus.engine_resetn = grant_oh;
                bus.vga_plot      = 1'b1;
                // cnt == 0 marks the first RUN cycle, where done may be left over from a prior pass.
                if (cnt != '0 && done_sel) begin
                    cnt_d   = '0;
                    state_d = (DRAIN == 0) ? S_RELEASE : S_DRAIN;
                end else if (cnt == RUN_LAST) begin
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                bus.engine_resetn = grant_oh;
                bus.vga_plot      = 1'b1;
                if (cnt == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                bus.done_pulse = grant_oh;
                rr_ptr_d       = grant_id_q;
                rr_valid_d     = 1'b1;
                cnt_d          = '0;
                state_d        = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            grant_id_q <= '0;
            rr_ptr     <= '0;
            rr_valid   <= 1'b0;
            cnt        <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_d;
            grant_id_q <= grant_d;
            rr_ptr     <= rr_ptr_d;
            rr_valid   <= rr_valid_d;
            cnt        <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_q;

    // At most one engine is ever out of reset.
    a_one_engine: assert property (@(posedge clk) $onehot0(bus.engine_resetn));
endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
- Sequences multiple full-region draw engines (stage-clear banners, map backgrounds, sprite blitters) that share the single VGA adapter write port.
- Each engine is held in reset until granted. The granted engine is released, then its x/y/colour are muxed to the VGA port and plot is gated until the engine reports done.
- Round-robin arbitration between level requests; one engine owns the port at a time.

Parameters:
- N_REQ, 4, number of draw engines (2..8)
- X_W, 8, VGA x width
- Y_W, 7, VGA y width
- C_W, 9, colour width
- PLOT_SKIP, 2, cycles after engine release before plot asserts (engine start delay + ROM read latency)
- DRAIN, 1, cycles plot stays high after done seen (last pixel still in flight)
- MAX_CYCLES, 16384, watchdog limit on cycles spent in RUN

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- req  in  N_REQ  level request per engine; held until its done_pulse
- engine_resetn  out  N_REQ  per-engine synchronous active-low reset; only the granted bit is high
- engine_done  in  N_REQ  per-engine done flag
- engine_x  in  N_REQ*X_W  packed x; engine i at [i*X_W +: X_W]
- engine_y  in  N_REQ*Y_W  packed y
- engine_colour  in  N_REQ*C_W  packed colour
- vga_x  out  X_W  muxed x to VGA adapter
- vga_y  out  Y_W  muxed y
- vga_colour  out  C_W  muxed colour
- vga_plot  out  1  write enable to VGA adapter
- busy  out  1  high in any state except IDLE
- grant_id  out  $clog2(N_REQ)  index of current or last grant
- done_pulse  out  N_REQ  one-cycle pulse to requester i when its draw completes
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (resetn low at posedge): state=IDLE, engine_resetn=0, vga_plot=0, busy=0, grant_id=0, done_pulse=0, timeout_err=0, rr pointer=0, counters=0.
- vga_x/y/colour are combinational muxes of the grant_id slice, valid in every state. They are qualified only by vga_plot.
- Round-robin: search starts at (last_grant+1) mod N_REQ. After reset the search starts at index 0. Ties are resolved by search order.
- IDLE: if req!=0, register the winner into grant_id and go to START. Otherwise stay in IDLE.
- START: engine_resetn[grant_id]=1 and stays 1 through RUN and DRAIN. Count PLOT_SKIP cycles with plot=0, then go to RUN.
  - With PLOT_SKIP=0, START lasts 1 cycle.
- RUN: vga_plot=1 every cycle. engine_done is ignored on the first RUN cycle (stale flag from the previous pass).
  - On engine_done[grant_id]=1: go to DRAIN, or to RELEASE if DRAIN=0.
  - Watchdog: the RUN cycle count reaching MAX_CYCLES sets timeout_err=1 and goes to RELEASE with no drain.
- DRAIN: vga_plot=1 for DRAIN cycles, then go to RELEASE.
- RELEASE: 1 cycle. vga_plot=0, engine_resetn=0, done_pulse[grant_id]=1, rr pointer=grant_id. Next state is IDLE.
  - A fresh grant therefore has at least 1 idle cycle. Back-to-back passes of the same engine are legal if its req is still high.
- req deasserted mid-draw: ignored; the draw completes.
- A req for the granted index that is still high in IDLE after its done_pulse is treated as a new request.
- engine_done of non-granted engines: ignored.
- resetn low mid-draw: immediate return to reset values. vga_plot drops on the same edge and all engines are held in reset.
- timeout_err clears only on resetn.

Test Plan:
- Single req[2]=1 with an engine model that sweeps 80x40 (3200 pixels) and raises done on the last address (PLOT_SKIP=2, DRAIN=1):
  - engine_resetn=4'b0100 one cycle after req is seen.
  - Plot starts 2 cycles later.
  - Exactly 3201 plot cycles.
  - done_pulse[2] one cycle after plot falls, then IDLE.
- req=4'b1111 held, each engine done after 10 cycles:
  - Grant order 0,1,2,3,0,...
  - Never two engine_resetn bits high.
  - vga_x/y match the granted engine's slice whenever plot=1.
- Stale done: engine 1 holds done=1 at release → RUN lasts at least 1 cycle, then exits. Engine 1 done asserted in the first RUN cycle only → ignored.
- Watchdog with MAX_CYCLES=16 and an engine that never asserts done:
  - timeout_err=1 after 16 RUN cycles.
  - done_pulse issued, scheduler returns to IDLE.
  - timeout_err stays 1 until resetn.
- resetn low at RUN cycle 100 → same edge: vga_plot=0, engine_resetn=0, busy=0. After resetn high, the next grant starts from index 0.
- engine_done[3]=1 while engine 0 is granted → no state change. req dropped mid-RUN → draw still completes with done_pulse.
